// File: rtl/keypad_unit_if.sv
// Keypad unit handshake bundle: data_mem request, hazard-unit
// pause/complete, converted value and entry status for the display.
interface keypad_unit_if;
  logic        input_enable;
  logic        input_complete;
  logic        cpu_pause;
  logic [31:0] input_value;
  logic        entry_active;
  logic [3:0]  digit_cnt;
  logic        entry_negative;

  modport master (
    input  input_enable,
    output input_complete,
    output cpu_pause,
    output input_value,
    output entry_active,
    output digit_cnt,
    output entry_negative
  );

  modport slave (
    output input_enable,
    input  input_complete,
    input  cpu_pause,
    input  input_value,
    input  entry_active,
    input  digit_cnt,
    input  entry_negative
  );
endinterface

// File: rtl/keypad_unit.sv
// 4x4 keypad scanner with debounce, decimal entry buffer and
// serial BCD-to-binary conversion feeding the hazard-unit handshake.
module keypad_unit #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 3,
  parameter int MAX_DIGITS   = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   row_in,
  output logic [3:0]   col_out,
  keypad_unit_if.master kp
);

  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CNT - 1);
  localparam logic [3:0]    MAXD     = 4'(MAX_DIGITS);

  localparam logic [3:0] K_A    = 4'd10;
  localparam logic [3:0] K_B    = 4'd11;
  localparam logic [3:0] K_C    = 4'd12;
  localparam logic [3:0] K_D    = 4'd13;
  localparam logic [3:0] K_STAR = 4'd14;
  localparam logic [3:0] K_HASH = 4'd15;

  localparam logic [1:0] S_SCAN  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_HELD  = 2'd2;

  localparam logic [1:0] E_IDLE  = 2'd0;
  localparam logic [1:0] E_ENTRY = 2'd1;
  localparam logic [1:0] E_CONV  = 2'd2;
  localparam logic [1:0] E_DONE  = 2'd3;

  logic [DW-1:0] div_q;
  logic          tick;
  logic [1:0]    sst;
  logic [1:0]    row_q;
  logic [CW-1:0] db_q;
  logic          key_stb;
  logic [3:0]    key_code;
  logic          low_any;
  logic [1:0]    low_row;
  logic [1:0]    col_idx;
  logic [3:0]    map_code;

  logic [1:0]    est;
  logic [3:0]    cnt_q;
  logic          neg_q;
  logic          pause_q;
  logic          cmp_q;
  logic [31:0]   val_q;
  logic [31:0]   acc_q;
  logic [3:0]    cidx_q;
  logic [3:0]    digits_q [MAX_DIGITS];

  assign tick    = (div_q == DIV_LAST);
  assign low_any = ~&row_in;

  // Later assignments win, so the lowest low row is the one kept.
  always_comb begin
    low_row = 2'd0;
    if (!row_in[3]) low_row = 2'd3;
    if (!row_in[2]) low_row = 2'd2;
    if (!row_in[1]) low_row = 2'd1;
    if (!row_in[0]) low_row = 2'd0;
  end

  always_comb begin
    col_idx = 2'd0;
    case (col_out)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  always_comb begin
    map_code = K_HASH;
    case ({row_q, col_idx})
      4'd0:    map_code = 4'd1;
      4'd1:    map_code = 4'd2;
      4'd2:    map_code = 4'd3;
      4'd3:    map_code = K_A;
      4'd4:    map_code = 4'd4;
      4'd5:    map_code = 4'd5;
      4'd6:    map_code = 4'd6;
      4'd7:    map_code = K_B;
      4'd8:    map_code = 4'd7;
      4'd9:    map_code = 4'd8;
      4'd10:   map_code = 4'd9;
      4'd11:   map_code = K_C;
      4'd12:   map_code = K_STAR;
      4'd13:   map_code = 4'd0;
      4'd14:   map_code = K_HASH;
      default: map_code = K_D;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      col_out  <= 4'b1110;
      sst      <= S_SCAN;
      row_q    <= 2'd0;
      db_q     <= '0;
      key_stb  <= 1'b0;
      key_code <= 4'd0;
    end else begin
      key_stb <= 1'b0;
      div_q   <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        case (sst)
          S_SCAN: begin
            if (low_any) begin
              row_q <= low_row;
              db_q  <= CW'(1);
              sst   <= S_PRESS;
            end else begin
              col_out <= {col_out[2:0], col_out[3]};
            end
          end
          S_PRESS: begin
            if (!row_in[row_q]) begin
              if (db_q == DB_LAST) begin
                key_stb  <= 1'b1;
                key_code <= map_code;
                db_q     <= '0;
                sst      <= S_HELD;
              end else begin
                db_q <= db_q + 1'b1;
              end
            end else begin
              sst <= S_SCAN;
            end
          end
          S_HELD: begin
            if (&row_in) begin
              if (db_q == DB_LAST) begin
                db_q <= '0;
                sst  <= S_SCAN;
              end else begin
                db_q <= db_q + 1'b1;
              end
            end else begin
              db_q <= '0;
            end
          end
          default: sst <= S_SCAN;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      est     <= E_IDLE;
      cnt_q   <= 4'd0;
      neg_q   <= 1'b0;
      pause_q <= 1'b0;
      cmp_q   <= 1'b0;
      val_q   <= 32'd0;
      acc_q   <= 32'd0;
      cidx_q  <= 4'd0;
    end else begin
      cmp_q <= 1'b0;
      if (key_stb && key_code == K_A) pause_q <= ~pause_q;
      case (est)
        E_IDLE: begin
          if (kp.input_enable) begin
            est   <= E_ENTRY;
            cnt_q <= 4'd0;
            neg_q <= 1'b0;
          end
        end
        E_ENTRY: begin
          if (!kp.input_enable) begin
            est <= E_IDLE;
          end else if (key_stb) begin
            unique case (1'b1)
              (key_code <= 4'd9): begin
                if (cnt_q < MAXD) begin
                  digits_q[cnt_q] <= key_code;
                  cnt_q <= cnt_q + 4'd1;
                end
              end
              (key_code == K_B): begin
                if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
              end
              (key_code == K_C): begin
                cnt_q <= 4'd0;
                neg_q <= 1'b0;
              end
              (key_code == K_STAR): neg_q <= ~neg_q;
              (key_code == K_D): begin
                acc_q  <= 32'd0;
                cidx_q <= 4'd0;
                est    <= (cnt_q == 4'd0) ? E_DONE : E_CONV;
              end
              default: ;
            endcase
          end
        end
        E_CONV: begin
          acc_q  <= (acc_q << 3) + (acc_q << 1)
                  + {28'd0, digits_q[cidx_q]};
          cidx_q <= cidx_q + 4'd1;
          if (cidx_q == cnt_q - 4'd1) est <= E_DONE;
        end
        default: begin
          val_q <= neg_q ? -acc_q : acc_q;
          cmp_q <= 1'b1;
          est   <= E_IDLE;
        end
      endcase
    end
  end

  assign kp.input_complete = cmp_q;
  assign kp.cpu_pause      = pause_q;
  assign kp.input_value    = val_q;
  assign kp.entry_active   = (est == E_ENTRY);
  assign kp.digit_cnt      = cnt_q;
  assign kp.entry_negative = neg_q;

endmodule

// File: tb/tb_keypad_unit.sv
// Bench for keypad_unit: directed scenarios plus random key taps,
// checked every cycle against a behavioural keypad/entry model.
module tb_keypad_unit;

  localparam int SD = 4;
  localparam int DC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_down;
  int         key_r;
  int         key_c;
  logic [3:0] rowpat;

  keypad_unit_if kp ();

  keypad_unit #(
    .SCAN_DIV(SD),
    .DEBOUNCE_CNT(DC),
    .MAX_DIGITS(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .row_in(row_in),
    .col_out(col_out),
    .kp(kp)
  );

  always #5 clk = ~clk;

  // A real keypad: the pressed key pulls its row low only while its column is driven.
  assign row_in = (key_down && col_out[key_c] == 1'b0) ? rowpat : 4'hF;

  // Key value by row*4+col: digits 0-9, A=10 B=11 C=12 D=13 *=14 #=15.
  int kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  int vectors = 0;
  int errs = 0;
  int n_cmp = 0;
  logic [31:0] last_val = 32'd0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      if (errs <= 40)
        $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model
  bit          m_live = 0;
  int          m_tick;
  int          m_col;
  int          m_mode;
  int          m_row;
  int          m_run;
  int          m_pend;
  bit          m_pause;
  bit          m_cmp;
  logic [31:0] m_val;
  int          m_est;
  int          q[$];
  bit          m_neg;
  int          m_left;
  logic [31:0] m_next;

  function automatic int first_low(logic [3:0] r);
    for (int i = 0; i < 4; i++) if (!r[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] value_of(int d[$], bit neg);
    longint acc = 0;
    foreach (d[i]) acc = acc * 10 + d[i];
    return neg ? 32'(-acc) : 32'(acc);
  endfunction

  always @(posedge clk) begin
    int low;
    m_live <= 1'b1;
    if (rst) begin
      m_tick = 0; m_col = 0; m_mode = 0; m_row = 0; m_run = 0;
      m_pend = -1; m_pause = 0; m_cmp = 0; m_val = 0;
      m_est = 0; q.delete(); m_neg = 0; m_left = 0;
    end else begin
      m_cmp = 0;
      if (m_pend == 10) m_pause = !m_pause;
      if (m_est == 2) begin
        m_left--;
        if (m_left == 0) begin
          m_cmp = 1; m_val = m_next; m_est = 0;
        end
      end else if (m_est == 0) begin
        if (kp.input_enable) begin
          m_est = 1; q.delete(); m_neg = 0;
        end
      end else if (!kp.input_enable) begin
        m_est = 0;
      end else if (m_pend >= 0) begin
        if (m_pend <= 9) begin
          if (q.size() < 9) q.push_back(m_pend);
        end else if (m_pend == 11) begin
          if (q.size() > 0) void'(q.pop_back());
        end else if (m_pend == 12) begin
          q.delete(); m_neg = 0;
        end else if (m_pend == 14) begin
          m_neg = !m_neg;
        end else if (m_pend == 13) begin
          m_next = value_of(q, m_neg);
          m_left = q.size() + 1;
          m_est = 2;
        end
      end
      m_pend = -1;
      if (m_tick == SD - 1) begin
        low = first_low(row_in);
        if (m_mode == 0) begin
          if (low >= 0) begin
            m_row = low; m_run = 1; m_mode = 1;
          end else m_col = (m_col + 1) % 4;
        end else if (m_mode == 1) begin
          if (!row_in[m_row]) begin
            m_run++;
            if (m_run == DC) begin
              m_pend = kmap[m_row * 4 + m_col];
              m_mode = 2; m_run = 0;
            end
          end else m_mode = 0;
        end else begin
          m_run = (row_in == 4'hF) ? m_run + 1 : 0;
          if (m_run == DC) begin
            m_mode = 0; m_run = 0;
          end
        end
      end
      m_tick = (m_tick + 1) % SD;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("col_out", {28'd0, col_out}, {28'd0, ~(4'b0001 << m_col)});
      chk("cpu_pause", {31'd0, kp.cpu_pause}, {31'd0, m_pause});
      chk("input_complete", {31'd0, kp.input_complete}, {31'd0, m_cmp});
      chk("input_value", kp.input_value, m_val);
      chk("entry_active", {31'd0, kp.entry_active}, {31'd0, m_est == 1});
      chk("digit_cnt", {28'd0, kp.digit_cnt}, 32'(q.size()));
      chk("entry_negative", {31'd0, kp.entry_negative}, {31'd0, m_neg});
    end
    if (kp.input_complete === 1'b1) begin
      n_cmp++;
      last_val = kp.input_value;
    end
  end

  task automatic tap_rc(int r, int c, int hold);
    @(negedge clk);
    key_r = r; key_c = c;
    rowpat = ~(4'b0001 << r);
    key_down = 1'b1;
    repeat (hold) @(negedge clk);
    key_down = 1'b0;
    repeat (5 * SD) @(negedge clk);
  endtask

  task automatic tap(int key);
    for (int i = 0; i < 16; i++)
      if (kmap[i] == key) begin
        tap_rc(i / 4, i % 4, 8 * SD);
        return;
      end
  endtask

  task automatic chk_reset_outs(string nm);
    chk({nm, "_col"}, {28'd0, col_out}, 32'hE);
    chk({nm, "_pause"}, {31'd0, kp.cpu_pause}, 32'd0);
    chk({nm, "_cmp"}, {31'd0, kp.input_complete}, 32'd0);
    chk({nm, "_val"}, kp.input_value, 32'd0);
    chk({nm, "_active"}, {31'd0, kp.entry_active}, 32'd0);
    chk({nm, "_cnt"}, {28'd0, kp.digit_cnt}, 32'd0);
    chk({nm, "_neg"}, {31'd0, kp.entry_negative}, 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    errs++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    int base;
    int k;
    string ten;
    rst = 1'b1; key_down = 1'b0; key_r = 0; key_c = 0; rowpat = 4'hF;
    kp.input_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] e;
      e = ~(4'b0001 << (i / 4));
      chk("scan_rotation", {28'd0, col_out}, {28'd0, e});
      @(negedge clk);
    end

    kp.input_enable = 1'b1;
    base = n_cmp;
    tap(1); chk("cnt_after_1", {28'd0, kp.digit_cnt}, 32'd1);
    tap(2); chk("cnt_after_2", {28'd0, kp.digit_cnt}, 32'd2);
    tap(3); chk("cnt_after_3", {28'd0, kp.digit_cnt}, 32'd3);
    tap(13);
    chk("pulse_count_123", 32'(n_cmp - base), 32'd1);
    chk("value_123", last_val, 32'd123);

    tap(4); tap(5); tap(11); tap(7); tap(14);
    chk("neg_before_d", {31'd0, kp.entry_negative}, 32'd1);
    chk("cnt_before_d", {28'd0, kp.digit_cnt}, 32'd2);
    tap(13);
    chk("value_m47", last_val, 32'hFFFF_FFD1);

    ten = "9876543210";
    for (int i = 0; i < 10; i++) tap(ten[i] - "0");
    chk("cnt_saturate", {28'd0, kp.digit_cnt}, 32'd9);
    tap(13);
    chk("value_9dig", last_val, 32'd987654321);

    kp.input_enable = 1'b0;
    repeat (4) @(negedge clk);
    base = n_cmp;
    tap(10); chk("pause_on", {31'd0, kp.cpu_pause}, 32'd1);
    tap(10); chk("pause_off", {31'd0, kp.cpu_pause}, 32'd0);
    chk("no_pulse_pause", 32'(n_cmp - base), 32'd0);

    // Bounce: A key low for exactly one debounce sample.
    k = 0;
    while (col_out[3] == 1'b0 && k < 64) begin @(negedge clk); k++; end
    key_r = 0; key_c = 3; rowpat = 4'b1110; key_down = 1'b1;
    k = 0;
    while (row_in == 4'hF && k < 64) begin @(negedge clk); k++; end
    chk("bounce_seen", {31'd0, k < 64}, 32'd1);
    repeat (6) @(negedge clk);
    key_down = 1'b0;
    repeat (5 * SD) @(negedge clk);
    chk("bounce_no_strobe", {31'd0, kp.cpu_pause}, 32'd0);

    kp.input_enable = 1'b1;
    tap(6); tap(8);
    chk("abort_cnt", {28'd0, kp.digit_cnt}, 32'd2);
    base = n_cmp;
    @(negedge clk); kp.input_enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_inactive", {31'd0, kp.entry_active}, 32'd0);
    chk("abort_no_pulse", 32'(n_cmp - base), 32'd0);
    chk("abort_value", kp.input_value, 32'd987654321);

    kp.input_enable = 1'b1;
    tap(10);
    for (int i = 0; i < 9; i++) tap(9);
    base = n_cmp;
    @(negedge clk);
    key_r = 3; key_c = 3; rowpat = 4'b0111; key_down = 1'b1;
    k = 0;
    while (kp.entry_active == 1'b1 && k < 100) begin @(negedge clk); k++; end
    chk("convert_reached", {31'd0, k < 100}, 32'd1);
    rst = 1'b1; key_down = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outs("rst_conv");
    rst = 1'b0;
    repeat (6 * SD) @(negedge clk);
    chk("rst_conv_no_pulse", 32'(n_cmp - base), 32'd0);

    kp.input_enable = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) kp.input_enable = ~kp.input_enable;
      if ($urandom_range(0, 5) == 0) kp.input_enable = 1'b1;
      tap_rc($urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(2, 40));
    end
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
